// File: rtl/mips_pkg.sv
// Shared hazard-unit definitions: stall reason encoding, default
// mult/div latency and the register-match helper.
package mips_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_LDUSE  = 2'd1,
        HZ_BRWAIT = 2'd2,
        HZ_MDWAIT = 2'd3
    } hazard_reason_t;

    localparam int         MULDIV_LAT_DEF = 4;
    localparam logic [4:0] REG_ZERO       = 5'd0;

    // A producer destination only matters when it is a real register and
    // the consumer actually reads that source field.
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] src,
                                       input logic       use_src);
        return use_src && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/muldiv_busy_timer.sv
// HI/LO busy timer: loaded when a mult/div leaves ID, counts down to zero.
module muldiv_busy_timer
    import mips_pkg::*;
#(
    parameter int LAT = MULDIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    logic [3:0] cnt_q;

    // Down-counter: a new mult/div reloads, otherwise drain to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= 4'(LAT);
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign busy = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard detection for the 5-stage pipeline: load-use, branch/jr operand
// waits and HI/LO busy produce a stall; taken branches and jumps squash IF/ID.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   HZ_RUN    | no stall last cycle
//   HZ_LDUSE  | stalled on a load feeding the ID instruction
//   HZ_BRWAIT | branch/jr waiting on an EX ALU or MEM load result
//   HZ_MDWAIT | mult/div or mfhi/mflo waiting on HI/LO busy
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UseRs_ID,
    input  logic             UseRt_ID,
    input  logic [4:0]       Dst_EX,
    input  logic [4:0]       Dst_MEM,
    input  logic             RegWrite_EX,
    input  logic             MemRead_EX,
    input  logic             MemRead_MEM,
    input  logic             Branch_ID,
    input  logic             Taken_ID,
    input  logic             Jump_ID,
    input  logic             MulDiv_ID,
    input  logic             UseHiLo_ID,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hazard_reason_t state_q, state_d;
    logic match_ex, match_mem;
    logic load_use, br_haz, md_haz;
    logic stall, flush;
    logic busy;

    muldiv_busy_timer #(.LAT(MULDIV_LAT)) u_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (MulDiv_ID && !stall),
        .busy  (busy)
    );

    // Hazard decode; jr reads Rs in ID like a branch, so it waits the same way.
    always_comb begin
        match_ex  = reg_match(Dst_EX, Rs_ID, UseRs_ID) || reg_match(Dst_EX, Rt_ID, UseRt_ID);
        match_mem = reg_match(Dst_MEM, Rs_ID, UseRs_ID) || reg_match(Dst_MEM, Rt_ID, UseRt_ID);
        load_use  = MemRead_EX && match_ex;
        br_haz    = (Branch_ID || (Jump_ID && UseRs_ID)) &&
                    ((RegWrite_EX && match_ex) || (MemRead_MEM && match_mem));
        md_haz    = busy && (UseHiLo_ID || MulDiv_ID);
        stall     = load_use || br_haz || md_haz;
        flush     = !stall && (Jump_ID || (Branch_ID && Taken_ID));
    end

    // Pipeline controls and next reason; reset forces the hold-with-bubble pattern.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        state_d      = HZ_RUN;
        if (md_haz) begin
            state_d = HZ_MDWAIT;
        end else if (load_use) begin
            state_d = HZ_LDUSE;
        end else if (br_haz) begin
            state_d = HZ_BRWAIT;
        end
        if (!rst_n) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (flush) begin
            IF_ID_Flush  = 1'b1;
        end
    end

    // Reason register, kept for trace visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (stall && (Stall_Cnt != CNT_MAX)) begin
                Stall_Cnt <= Stall_Cnt + 1'b1;
            end
            if (flush && (Flush_Cnt != CNT_MAX)) begin
                Flush_Cnt <= Flush_Cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a per-cycle reference model.
module tb_hazard_stall_unit;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] Rs_ID, Rt_ID, Dst_EX, Dst_MEM;
    logic UseRs_ID, UseRt_ID, RegWrite_EX, MemRead_EX, MemRead_MEM;
    logic Branch_ID, Taken_ID, Jump_ID, MulDiv_ID, UseHiLo_ID;
    logic PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;

    int checks = 0;
    int errors = 0;

    int m_busy = 0, m_scnt = 0, m_fcnt = 0;
    int n_busy = 0, n_scnt = 0, n_fcnt = 0;

    hazard_stall_unit #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rs_ID        (Rs_ID),
        .Rt_ID        (Rt_ID),
        .UseRs_ID     (UseRs_ID),
        .UseRt_ID     (UseRt_ID),
        .Dst_EX       (Dst_EX),
        .Dst_MEM      (Dst_MEM),
        .RegWrite_EX  (RegWrite_EX),
        .MemRead_EX   (MemRead_EX),
        .MemRead_MEM  (MemRead_MEM),
        .Branch_ID    (Branch_ID),
        .Taken_ID     (Taken_ID),
        .Jump_ID      (Jump_ID),
        .MulDiv_ID    (MulDiv_ID),
        .UseHiLo_ID   (UseHiLo_ID),
        .PC_Write     (PC_Write),
        .IF_ID_Write  (IF_ID_Write),
        .ID_EX_Bubble (ID_EX_Bubble),
        .IF_ID_Flush  (IF_ID_Flush),
        .Stall_Cnt    (Stall_Cnt),
        .Flush_Cnt    (Flush_Cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: evaluate the hazard rules on the current inputs.
    always @(negedge clk) begin
        bit hit_ex, hit_mem, branchy, e_stall, e_flush;
        logic [4:0] src;
        bit use_src;
        if (!rst_n) begin
            chk("rst_pc", PC_Write, 0);
            chk("rst_ifid", IF_ID_Write, 0);
            chk("rst_bubble", ID_EX_Bubble, 1);
            chk("rst_flush", IF_ID_Flush, 0);
            chk("rst_scnt", Stall_Cnt, 0);
            chk("rst_fcnt", Flush_Cnt, 0);
            m_busy = 0; m_scnt = 0; m_fcnt = 0;
            n_busy = 0; n_scnt = 0; n_fcnt = 0;
        end else begin
            hit_ex = 0;
            hit_mem = 0;
            for (int s = 0; s < 2; s++) begin
                src     = (s == 0) ? Rs_ID : Rt_ID;
                use_src = (s == 0) ? UseRs_ID : UseRt_ID;
                if (use_src && src != 0) begin
                    if (src == Dst_EX)  hit_ex = 1;
                    if (src == Dst_MEM) hit_mem = 1;
                end
            end
            branchy = Branch_ID || (Jump_ID && UseRs_ID);
            e_stall = (MemRead_EX && hit_ex)
                   || (branchy && ((RegWrite_EX && hit_ex) || (MemRead_MEM && hit_mem)))
                   || (m_busy > 0 && (UseHiLo_ID || MulDiv_ID));
            e_flush = !e_stall && (Jump_ID || (Branch_ID && Taken_ID));
            chk("cmp_pc", PC_Write, !e_stall);
            chk("cmp_ifid", IF_ID_Write, !e_stall);
            chk("cmp_bubble", ID_EX_Bubble, e_stall);
            chk("cmp_flush", IF_ID_Flush, e_flush);
            chk("cmp_scnt", Stall_Cnt, m_scnt);
            chk("cmp_fcnt", Flush_Cnt, m_fcnt);
            if (MulDiv_ID && !e_stall) n_busy = LAT;
            else                       n_busy = (m_busy > 0) ? m_busy - 1 : 0;
            n_scnt = (e_stall && m_scnt < CMAX) ? m_scnt + 1 : m_scnt;
            n_fcnt = (e_flush && m_fcnt < CMAX) ? m_fcnt + 1 : m_fcnt;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_busy = n_busy;
            m_scnt = n_scnt;
            m_fcnt = n_fcnt;
        end
    end

    task automatic idle();
        Rs_ID = 0; Rt_ID = 0; Dst_EX = 0; Dst_MEM = 0;
        UseRs_ID = 0; UseRt_ID = 0; RegWrite_EX = 0; MemRead_EX = 0; MemRead_MEM = 0;
        Branch_ID = 0; Taken_ID = 0; Jump_ID = 0; MulDiv_ID = 0; UseHiLo_ID = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        step(2);
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle();
        step(2);
        #1;
        chk("reset_pc", PC_Write, 0);
        chk("reset_bubble", ID_EX_Bubble, 1);
        rst_n = 1;

        // Load-use: lw $2 in EX, add reads $2.
        step(1);
        MemRead_EX = 1; RegWrite_EX = 1; Dst_EX = 2; Rs_ID = 2; UseRs_ID = 1;
        #1;
        chk("lu_pc", PC_Write, 0);
        chk("lu_bubble", ID_EX_Bubble, 1);
        step(1);
        MemRead_EX = 0; RegWrite_EX = 0; Dst_EX = 0; MemRead_MEM = 1; Dst_MEM = 2;
        #1;
        chk("lu_free_pc", PC_Write, 1);
        chk("lu_scnt", Stall_Cnt, 1);

        // $zero destination never matches.
        step(1);
        idle();
        MemRead_EX = 1; Dst_EX = 0; Rs_ID = 0; UseRs_ID = 1;
        #1;
        chk("zero_pc", PC_Write, 1);

        // Unused Rt field ignored.
        step(1);
        idle();
        MemRead_EX = 1; Dst_EX = 9; Rt_ID = 9; UseRt_ID = 0;
        #1;
        chk("nouse_pc", PC_Write, 1);
        step(1);

        // beq on load result: two stalls, then taken -> one flush.
        do_reset();
        Branch_ID = 1; Rs_ID = 3; UseRs_ID = 1; MemRead_EX = 1; RegWrite_EX = 1; Dst_EX = 3;
        #1;
        chk("bld_pc0", PC_Write, 0);
        chk("bld_flush0", IF_ID_Flush, 0);
        step(1);
        MemRead_EX = 0; RegWrite_EX = 0; Dst_EX = 0; MemRead_MEM = 1; Dst_MEM = 3;
        #1;
        chk("bld_pc1", PC_Write, 0);
        step(1);
        MemRead_MEM = 0; Dst_MEM = 0; Taken_ID = 1;
        #1;
        chk("bld_flush", IF_ID_Flush, 1);
        chk("bld_pc2", PC_Write, 1);
        chk("bld_scnt", Stall_Cnt, 2);
        step(1);
        idle();
        #1;
        chk("bld_flush_off", IF_ID_Flush, 0);
        chk("bld_fcnt", Flush_Cnt, 1);

        // Branch on ALU result in EX: one stall.
        step(1);
        Branch_ID = 1; Rt_ID = 7; UseRt_ID = 1; RegWrite_EX = 1; Dst_EX = 7;
        #1;
        chk("balu_pc0", PC_Write, 0);
        step(1);
        RegWrite_EX = 0; Dst_EX = 0; Dst_MEM = 7;
        #1;
        chk("balu_pc1", PC_Write, 1);
        step(1);

        // mult, one unrelated slot, then mflo: stalled while busy is 3,2,1.
        do_reset();
        MulDiv_ID = 1;
        step(1);
        MulDiv_ID = 0;
        step(1);
        UseHiLo_ID = 1;
        #1;
        chk("md_pc0", PC_Write, 0);
        step(1);
        chk("md_pc1", PC_Write, 0);
        step(1);
        chk("md_pc2", PC_Write, 0);
        step(1);
        chk("md_pc3", PC_Write, 1);
        chk("md_scnt", Stall_Cnt, 3);

        // Back-to-back mult/div: second waits for busy to drain, then reloads.
        step(1);
        idle();
        MulDiv_ID = 1;
        step(1);
        step(6);
        MulDiv_ID = 0;
        UseHiLo_ID = 1;
        step(6);

        // jr coincident with load-use on Rs: stall wins, flush once it clears.
        do_reset();
        Jump_ID = 1; Rs_ID = 5; UseRs_ID = 1; MemRead_EX = 1; RegWrite_EX = 1; Dst_EX = 5;
        #1;
        chk("jr_flush0", IF_ID_Flush, 0);
        step(1);
        MemRead_EX = 0; RegWrite_EX = 0; Dst_EX = 0; MemRead_MEM = 1; Dst_MEM = 5;
        #1;
        chk("jr_flush1", IF_ID_Flush, 0);
        step(1);
        MemRead_MEM = 0; Dst_MEM = 0;
        #1;
        chk("jr_flush2", IF_ID_Flush, 1);
        step(1);

        // Reset during MDWAIT with busy=2.
        do_reset();
        MulDiv_ID = 1;
        step(1);
        MulDiv_ID = 0; UseHiLo_ID = 1;
        step(2);
        chk("mdrst_pre_scnt", Stall_Cnt, 2);
        rst_n = 0;
        #1;
        chk("mdrst_scnt", Stall_Cnt, 0);
        chk("mdrst_fcnt", Flush_Cnt, 0);
        chk("mdrst_pc", PC_Write, 0);
        chk("mdrst_bubble", ID_EX_Bubble, 1);
        step(1);
        rst_n = 1;
        UseHiLo_ID = 1;
        #1;
        chk("mdrst_after_pc", PC_Write, 1);
        chk("mdrst_after_bubble", ID_EX_Bubble, 0);
        step(1);

        // Counter saturation.
        do_reset();
        MemRead_EX = 1; Dst_EX = 4; Rs_ID = 4; UseRs_ID = 1;
        step(20);
        chk("sat_scnt", Stall_Cnt, CMAX);
        idle();
        Jump_ID = 1;
        step(20);
        chk("sat_fcnt", Flush_Cnt, CMAX);
        chk("sat_scnt_hold", Stall_Cnt, CMAX);
        idle();
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
